// File: rtl/painel_rotador_if.sv
// Bus bundle for the LED line rotator: mode/prescaler/load inputs and registered column view.
// load_en is a one-cycle strobe sampled on every rising edge; there is no valid/ready backpressure.
interface painel_rotador_if #(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 7,
  parameter int DIV_W  = 4,
  parameter int PW     = $clog2(WIDTH)
);
  logic              ch0;
  logic              ch1;
  logic [DIV_W-1:0]  div;
  logic              load_en;
  logic [WIDTH-1:0]  load_data;
  logic [WINDOW-1:0] saida;
  logic [PW-1:0]     pos;
  logic              step;
  logic              wrap;
  logic              dbg_dir;

  modport master (
    output ch0, ch1, div, load_en, load_data,
    input  saida, pos, step, wrap, dbg_dir
  );

  modport slave (
    input  ch0, ch1, div, load_en, load_data,
    output saida, pos, step, wrap, dbg_dir
  );
endinterface

// File: rtl/painel_rotador.sv
// Circular display register: rotates a WIDTH-bit line left, right or bouncing at a
// prescaled rate and presents the leftmost WINDOW bits to the LED column drivers.
module painel_rotador #(
  parameter int                WIDTH  = 16,
  parameter int                WINDOW = 7,
  parameter int                DIV_W  = 4,
  parameter logic [WIDTH-1:0]  INIT   = 16'b1010_1000_1000_0010,
  parameter int                PW     = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  painel_rotador_if.slave  bus
);

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

  localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
  localparam logic [PW-1:0] POS_L   = PW'(WIDTH - WINDOW);

  logic [WIDTH-1:0]  r, r_nx;
  logic [WIDTH-1:0]  pat, pat_nx;
  logic [DIV_W-1:0]  cnt, cnt_nx;
  logic [PW-1:0]     pos, pos_nx;
  dir_t              dir, dir_nx;
  logic [WINDOW-1:0] saida, saida_nx;
  logic              step, step_nx;
  logic              wrap, wrap_nx;
  logic [1:0]        mode;
  logic              rot_l, rot_r;

  assign mode = {bus.ch1, bus.ch0};

  always_comb begin
    r_nx    = r;
    pat_nx  = pat;
    cnt_nx  = cnt;
    pos_nx  = pos;
    dir_nx  = dir;
    step_nx = 1'b0;
    wrap_nx = 1'b0;
    rot_l   = 1'b0;
    rot_r   = 1'b0;

    if (bus.load_en) begin
      pat_nx = bus.load_data;
      r_nx   = bus.load_data;
      cnt_nx = '0;
      pos_nx = '0;
      dir_nx = DIR_LEFT;
    end else if (mode == 2'b00) begin
      r_nx   = pat;
      cnt_nx = '0;
      pos_nx = '0;
      dir_nx = DIR_LEFT;
    end else if (cnt >= bus.div) begin
      cnt_nx = '0;
      unique case (mode)
        2'b01:   rot_l = 1'b1;
        2'b10:   rot_r = 1'b1;
        default: begin
          // Bounce turns around at the window edge L and at 0, so pos never wraps.
          if (dir == DIR_LEFT && pos >= POS_L) begin
            dir_nx = DIR_RIGHT;
            rot_r  = 1'b1;
          end else if (dir == DIR_RIGHT && pos == '0) begin
            dir_nx = DIR_LEFT;
            rot_l  = 1'b1;
          end else if (dir == DIR_LEFT) begin
            rot_l  = 1'b1;
          end else begin
            rot_r  = 1'b1;
          end
        end
      endcase
    end else begin
      cnt_nx = cnt + DIV_W'(1);
    end

    if (rot_l) begin
      r_nx    = {r[WIDTH-2:0], r[WIDTH-1]};
      pos_nx  = (pos == POS_MAX) ? '0 : pos + PW'(1);
      wrap_nx = (pos == POS_MAX);
      step_nx = 1'b1;
    end else if (rot_r) begin
      r_nx    = {r[0], r[WIDTH-1:1]};
      pos_nx  = (pos == '0) ? POS_MAX : pos - PW'(1);
      wrap_nx = (pos == '0);
      step_nx = 1'b1;
    end

    saida_nx = '0;
    if (bus.load_en || mode != 2'b00) saida_nx = r_nx[WIDTH-1 -: WINDOW];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r     <= INIT;
      pat   <= INIT;
      cnt   <= '0;
      pos   <= '0;
      dir   <= DIR_LEFT;
      saida <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      r     <= r_nx;
      pat   <= pat_nx;
      cnt   <= cnt_nx;
      pos   <= pos_nx;
      dir   <= dir_nx;
      saida <= saida_nx;
      step  <= step_nx;
      wrap  <= wrap_nx;
    end
  end

  assign bus.saida   = saida;
  assign bus.pos     = pos;
  assign bus.step    = step;
  assign bus.wrap    = wrap;
  assign bus.dbg_dir = (dir == DIR_RIGHT);

endmodule

// File: tb/tb_painel_rotador.sv
// Directed bench for painel_rotador: a pattern/offset model checked every cycle plus literal pins.
module tb_painel_rotador;
  localparam int W   = 16;
  localparam int WIN = 7;
  localparam int DW  = 4;
  localparam int PW  = 4;
  localparam int L   = W - WIN;
  localparam logic [W-1:0] INIT = 16'b1010_1000_1000_0010;

  logic CLK;
  logic RST_N;
  int   checks = 0;
  int   errors = 0;

  painel_rotador_if #(.WIDTH(W), .WINDOW(WIN), .DIV_W(DW)) bus ();

  painel_rotador #(.WIDTH(W), .WINDOW(WIN), .DIV_W(DW), .INIT(INIT)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- model ----------------
  // The displayed line is always the base pattern rotated left by pos.
  logic [W-1:0] m_pat;
  int           m_pos, m_cnt, m_dir;
  logic         m_on, m_step, m_wrap;

  task automatic model_reset();
    m_pat = INIT; m_pos = 0; m_cnt = 0; m_dir = 0;
    m_on = 1'b0; m_step = 1'b0; m_wrap = 1'b0;
  endtask

  function automatic logic [WIN-1:0] exp_saida();
    logic [WIN-1:0] e;
    e = '0;
    if (m_on)
      for (int j = 0; j < WIN; j++) e[j] = m_pat[((W - WIN + j - m_pos) % W + W) % W];
    return e;
  endfunction

  always @(negedge RST_N) model_reset();

  always @(posedge CLK) begin
    if (RST_N) begin
      int mode, d;
      mode   = {bus.ch1, bus.ch0};
      m_step = 1'b0;
      m_wrap = 1'b0;
      if (bus.load_en) begin
        m_pat = bus.load_data; m_pos = 0; m_cnt = 0; m_dir = 0; m_on = 1'b1;
      end else if (mode == 0) begin
        m_pos = 0; m_cnt = 0; m_dir = 0; m_on = 1'b0;
      end else begin
        m_on = 1'b1;
        if (m_cnt >= int'(bus.div)) begin
          m_cnt  = 0;
          m_step = 1'b1;
          if (mode == 1) d = 0;
          else if (mode == 2) d = 1;
          else begin
            if (m_dir == 0 && m_pos >= L) m_dir = 1;
            else if (m_dir == 1 && m_pos == 0) m_dir = 0;
            d = m_dir;
          end
          if (d == 0) begin
            m_pos  = (m_pos + 1) % W;
            m_wrap = (m_pos == 0);
          end else begin
            m_pos  = (m_pos + W - 1) % W;
            m_wrap = (m_pos == W - 1);
          end
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    chk("m_saida", int'(bus.saida), int'(exp_saida()));
    chk("m_pos", int'(bus.pos), m_pos);
    chk("m_step", int'(bus.step), int'(m_step));
    chk("m_wrap", int'(bus.wrap), int'(m_wrap));
    chk("m_dir", int'(bus.dbg_dir), m_dir);
  end

  // ---------------- driver tasks ----------------
  task automatic edges(int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic set_mode(logic c1, logic c0, int d);
    bus.ch1 = c1;
    bus.ch0 = c0;
    bus.div = DW'(d);
  endtask

  // ---------------- directed sequence ----------------
  int bpos [18] = '{1,2,3,4,5,6,7,8,9,8,7,6,5,4,3,2,1,0};

  initial begin
    RST_N = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_data = '0;
    set_mode(1'b0, 1'b0, 0);
    model_reset();
    edges(3);
    chk("rst_saida", int'(bus.saida), 0);
    chk("rst_pos", int'(bus.pos), 0);
    chk("rst_step", int'(bus.step), 0);

    // rotate left, full revolution
    set_mode(1'b0, 1'b1, 0);
    @(negedge CLK); RST_N = 1'b1;
    edges(1);
    chk("l1_saida", int'(bus.saida), 'h28);
    chk("l1_pos", int'(bus.pos), 1);
    chk("l1_step", int'(bus.step), 1);
    edges(14);
    chk("l15_pos", int'(bus.pos), 15);
    chk("l15_wrap", int'(bus.wrap), 0);
    edges(1);
    chk("l16_saida", int'(bus.saida), 'h54);
    chk("l16_pos", int'(bus.pos), 0);
    chk("l16_wrap", int'(bus.wrap), 1);

    // rotate right from pos 0
    set_mode(1'b1, 1'b0, 0);
    edges(1);
    chk("r1_saida", int'(bus.saida), 'h2A);
    chk("r1_pos", int'(bus.pos), 15);
    chk("r1_wrap", int'(bus.wrap), 1);
    chk("r1_step", int'(bus.step), 1);

    // stop, then left with div=3
    set_mode(1'b0, 1'b0, 3);
    edges(1);
    chk("stop_saida", int'(bus.saida), 0);
    chk("stop_pos", int'(bus.pos), 0);
    set_mode(1'b0, 1'b1, 3);
    edges(3);
    chk("d3_nostep", int'(bus.step), 0);
    chk("d3_hold", int'(bus.saida), 'h54);
    for (int k = 1; k <= 3; k++) begin
      edges(1);
      chk("d3_pos", int'(bus.pos), k);
      chk("d3_step", int'(bus.step), 1);
      if (k < 3) begin
        edges(3);
        chk("d3_gap", int'(bus.step), 0);
      end
    end

    // bounce
    set_mode(1'b0, 1'b0, 0);
    edges(1);
    set_mode(1'b1, 1'b1, 0);
    for (int t = 0; t < 19; t++) begin
      edges(1);
      chk("b_pos", int'(bus.pos), (t < 18) ? bpos[t] : 1);
      chk("b_wrap", int'(bus.wrap), 0);
    end

    // load mid-count, then stop, then left again
    set_mode(1'b0, 1'b0, 3);
    edges(1);
    set_mode(1'b0, 1'b1, 3);
    edges(2);
    bus.load_en = 1'b1;
    bus.load_data = 16'hFFFF;
    edges(1);
    bus.load_en = 1'b0;
    chk("ld_saida", int'(bus.saida), 'h7F);
    chk("ld_pos", int'(bus.pos), 0);
    chk("ld_step", int'(bus.step), 0);
    set_mode(1'b0, 1'b0, 3);
    edges(1);
    chk("ld_stop", int'(bus.saida), 0);
    set_mode(1'b0, 1'b1, 3);
    edges(1);
    chk("ld_back", int'(bus.saida), 'h7F);

    // asynchronous reset mid-count
    set_mode(1'b0, 1'b1, 5);
    edges(6);
    #1;
    RST_N = 1'b0;
    #1;
    chk("ar_saida", int'(bus.saida), 0);
    chk("ar_pos", int'(bus.pos), 0);
    chk("ar_step", int'(bus.step), 0);
    @(negedge CLK); RST_N = 1'b1;
    edges(5);
    chk("ar5_saida", int'(bus.saida), 'h54);
    edges(1);
    chk("ar6_saida", int'(bus.saida), 'h28);
    chk("ar6_pos", int'(bus.pos), 1);

    edges(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
